inst_loader: RTL and testbench

- Initiator on the inst_sram write port: receives a program as a byte stream and writes it word-by-word into inst_sram.
- Assembles 4 little-endian bytes into one 32-bit instruction and issues a single-cycle write at consecutive word addresses.
- Holds the core's fetch side off via inst_sram_en=0 and load_busy until the load completes; then releases fetch.

---
 rtl/inst_mem_pkg.sv | 23 ++
 rtl/inst_loader_if.sv | 28 ++
 rtl/inst_word_packer.sv | 32 +++
 rtl/inst_loader.sv | 151 +++++++++++++++
 tb/tb_inst_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding, bus
// widths and the default load address.
// Optional build macro: INST_LOADER_CHECKSUM_EN adds the CHECK state.
package inst_mem_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 64'd1;

    // Explicit encodings keep the debug state value stable across builds.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3
`ifdef INST_LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Loader-facing bus: the incoming byte stream plus the inst_sram write and
// fetch-enable signals. The loader drives through the master modport.
//
// Byte stream handshake: a byte moves from producer to loader on a rising
// clk edge where rx_valid && rx_ready are both high. rx_valid/rx_data must
// stay stable until accepted; rx_ready never depends on rx_valid.
interface inst_loader_if;
    import inst_mem_pkg::*;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              inst_sram_wen;
    logic [ADDR_W-1:0] inst_sram_waddr;
    logic [INST_W-1:0] inst_sram_wdata;
    logic              inst_sram_en;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata, inst_sram_en
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, inst_sram_wen, inst_sram_waddr, inst_sram_wdata, inst_sram_en
    );

endinterface

// File: rtl/inst_word_packer.sv
// Assembles four little-endian bytes into one 32-bit word. word_valid is a
// combinational pulse marking the handshake that carries the fourth byte.
module inst_word_packer
    import inst_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [INST_W-1:0] word,
    output logic              word_valid
);

    logic [1:0] idx_q;

    assign word_valid = byte_valid && (idx_q == 2'd3);

    // Drop byte k into lane k; clear restarts assembly at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            word  <= '0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (byte_valid) begin
            word[{idx_q, 3'b000} +: 8] <= byte_data;
            idx_q                      <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader: receives a byte stream, writes 32-bit words into inst_sram
// at consecutive word addresses and holds fetch off until the load finishes.
// Optional build macro: INST_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module inst_loader
    import inst_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_cnt,
    inst_loader_if.master    bus,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output state_t           dbg_state
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  waddr_q;
    logic [CNT_W-1:0]   remain_q;
    logic               done_q;
    logic               start_ok;
    logic               byte_fire;
    logic               word_valid;
    logic [INST_W-1:0]  word;
    logic               rx_ready;
    logic               wen;
    logic               fetch_en;
    logic               busy;

    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign byte_fire = (state_q == ST_RECV) && bus.rx_valid;

    inst_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_valid (byte_fire),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        wen      = 1'b0;
        fetch_en = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (word_cnt == '0) ? ST_DONE : ST_RECV;
            end
            ST_RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wen  = 1'b1;
                busy = 1'b1;
                if (remain_q == CNT_W'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_RECV;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (bus.rx_valid) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                fetch_en = 1'b1;
                if (start) state_d = (word_cnt == '0) ? ST_DONE : ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address and remaining-word counters; both step after each write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q  <= BASE_ADDR;
            remain_q <= '0;
        end else if (start_ok && word_cnt != '0) begin
            waddr_q  <= BASE_ADDR;
            remain_q <= word_cnt;
        end else if (state_q == ST_WRITE) begin
            waddr_q  <= waddr_q + 64'd1;
            remain_q <= remain_q - CNT_W'(1);
        end
    end

    // Sticky done: cleared by a real start, set on any entry into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        done_q <= 1'b0;
        else if (start_ok) done_q <= (word_cnt == '0);
        else               done_q <= done_q || (state_d == ST_DONE);
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       err_q;

    // Running XOR of payload bytes; the byte taken in CHECK is compared to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= 8'd0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            xor_q <= 8'd0;
            err_q <= 1'b0;
        end else if (byte_fire) begin
            xor_q <= xor_q ^ bus.rx_data;
        end else if (state_q == ST_CHECK && bus.rx_valid) begin
            err_q <= err_q || (bus.rx_data != xor_q);
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign bus.rx_ready        = rx_ready;
    assign bus.inst_sram_wen   = wen;
    assign bus.inst_sram_waddr = waddr_q;
    assign bus.inst_sram_wdata = word;
    assign bus.inst_sram_en    = fetch_en;
    assign load_busy           = busy;
    assign load_done           = done_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected writes are queued as stimulus is
// issued and a monitor branch pops and compares on every inst_sram_wen.
// Optional build macro: INST_LOADER_CHECKSUM_EN enables the checksum cases.
module tb_inst_loader;
    import inst_mem_pkg::*;

    localparam int W = ADDR_W + INST_W;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] word_cnt = 16'd0;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    state_t      dbg_state;

    inst_loader_if bus ();

    inst_loader #(
        .BASE_ADDR (64'd1),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .word_cnt  (word_cnt),
        .bus       (bus),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    logic [7:0] prog [16] = '{
        8'h13, 8'h01, 8'h40, 8'h01,
        8'h93, 8'h01, 8'h51, 8'h00,
        8'h13, 8'h0A, 8'h10, 8'h00,
        8'hA3, 8'h30, 8'h3A, 8'h00
    };
    logic [31:0] words [4] = '{32'h01400113, 32'h00510193, 32'h00100A13, 32'h003A30A3};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Scoreboard monitor: every write strobe must match the queue head.
    task automatic monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.inst_sram_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: got addr=%h data=%h expected no write",
                             bus.inst_sram_waddr, bus.inst_sram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr", {bus.inst_sram_waddr, bus.inst_sram_wdata}, e);
                end
            end
        end
    endtask

    // Driver tasks: entered and left at posedge+1.
    task automatic do_start(input logic [15:0] n);
        start    = 1'b1;
        word_cnt = n;
        @(posedge clk); #1;
        start    = 1'b0;
        word_cnt = 16'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) taken = 1'b1;
            @(posedge clk); #1;
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL rx_timeout: got no rx_ready for byte %h expected acceptance", b);
        end
    endtask

    task automatic send_word(input int idx, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(prog[4*idx + k]);
            if (gap) begin
                bus.rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) seen = 1'b1;
        end
        check(name, W'(seen), W'(1));
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wen",   W'(bus.inst_sram_wen),   W'(0));
        check("rst_waddr", W'(bus.inst_sram_waddr), W'(64'd1));
        check("rst_en",    W'(bus.inst_sram_en),    W'(0));
        check("rst_ready", W'(bus.rx_ready),        W'(0));
        check("rst_busy",  W'(load_busy),           W'(0));
        check("rst_done",  W'(load_done),           W'(0));
        check("rst_err",   W'(load_err),            W'(0));
        check("rst_state", W'(dbg_state),           W'(ST_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Four-word load with a continuous stream.
        for (int i = 0; i < 4; i++) push(64'(i + 1), words[i]);
        do_start(16'd4);
        check("t1_busy", W'(load_busy), W'(1));
        for (int i = 0; i < 4; i++) send_word(i, 1'b0);
        bus.rx_valid = 1'b0;
        wait_done("t1_done");
        check("t1_en",    W'(bus.inst_sram_en),    W'(1));
        check("t1_busy2", W'(load_busy),           W'(0));
        check("t1_state", W'(dbg_state),           W'(ST_DONE));
        check("t1_waddr", W'(bus.inst_sram_waddr), W'(64'd5));
        check("t1_drain", W'(exp_q.size()),        W'(0));

        // Same load with rx_valid toggling every other cycle.
        for (int i = 0; i < 4; i++) push(64'(i + 1), words[i]);
        do_start(16'd4);
        check("t2_done_clr", W'(load_done), W'(0));
        check("t2_en_off",   W'(bus.inst_sram_en), W'(0));
        for (int i = 0; i < 4; i++) send_word(i, 1'b1);
        wait_done("t2_done");
        check("t2_drain", W'(exp_q.size()), W'(0));

        // Reset after six bytes: only the first word was written.
        push(64'd1, words[0]);
        do_start(16'd4);
        for (int k = 0; k < 6; k++) send_byte(prog[k]);
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t3_wen",   W'(bus.inst_sram_wen),   W'(0));
        check("t3_state", W'(dbg_state),           W'(ST_IDLE));
        check("t3_busy",  W'(load_busy),           W'(0));
        check("t3_waddr", W'(bus.inst_sram_waddr), W'(64'd1));
        check("t3_drain", W'(exp_q.size()),        W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero-word load: no write, done one cycle after start.
        start    = 1'b1;
        word_cnt = 16'd0;
        @(negedge clk);
        check("t4_done_pre", W'(load_done), W'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_done",  W'(load_done), W'(1));
        check("t4_state", W'(dbg_state), W'(ST_DONE));
        check("t4_en",    W'(bus.inst_sram_en), W'(1));
        @(posedge clk); #1;

        // Fresh two-word load from address 1; start mid-RECV is ignored.
        push(64'd1, words[2]);
        push(64'd2, words[3]);
        do_start(16'd2);
        send_byte(prog[8]);
        send_byte(prog[9]);
        bus.rx_valid = 1'b0;
        start    = 1'b1;
        word_cnt = 16'd7;
        @(posedge clk); #1;
        start    = 1'b0;
        word_cnt = 16'd0;
        @(negedge clk);
        check("t5_state", W'(dbg_state),           W'(ST_RECV));
        check("t5_waddr", W'(bus.inst_sram_waddr), W'(64'd1));
        @(posedge clk); #1;
        for (int k = 10; k < 16; k++) send_byte(prog[k]);
        bus.rx_valid = 1'b0;
        wait_done("t5_done");
        check("t5_waddr_end", W'(bus.inst_sram_waddr), W'(64'd3));
        check("t5_drain",     W'(exp_q.size()),        W'(0));

`ifdef INST_LOADER_CHECKSUM_EN
        // Correct checksum: 13^01^40^01 = 53.
        push(64'd1, words[0]);
        do_start(16'd1);
        send_word(0, 1'b0);
        send_byte(8'h53);
        bus.rx_valid = 1'b0;
        wait_done("c1_done");
        check("c1_err",   W'(load_err),         W'(0));
        check("c1_en",    W'(bus.inst_sram_en), W'(1));
        check("c1_drain", W'(exp_q.size()),     W'(0));

        // Wrong checksum.
        push(64'd1, words[0]);
        do_start(16'd1);
        send_word(0, 1'b0);
        send_byte(8'h00);
        bus.rx_valid = 1'b0;
        wait_done("c2_done");
        check("c2_err",   W'(load_err),         W'(1));
        check("c2_en",    W'(bus.inst_sram_en), W'(1));
        check("c2_drain", W'(exp_q.size()),     W'(0));
`else
        check("err_tied", W'(load_err), W'(0));
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
